// File: rtl/tpu_byte_loader.sv
// tpu_byte_loader: byte-serial header/payload front end that fills NxN weight and activation matrices and starts the systolic array (optional watchdog: LOADER_TIMEOUT_EN)
module tpu_byte_loader #(
    parameter int N       = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N*N*DATA_W-1:0]    w_flat,
    output logic [N*N*DATA_W-1:0]    a_flat,
    output logic                     mat_start,
    input  logic                     mat_done,
    output logic                     busy,
    output logic                     err
);
    localparam int NE = N * N;
    localparam int CW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_A, S_FIRE, S_WAIT} state_t;

    state_t                 r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic                   r_w_loaded, r_a_loaded, r_err, r_mat_start;
    logic [NE*DATA_W-1:0]   r_w, r_a;
    logic                   w_xfer, w_last, w_both, w_timeout;
    logic [1:0]             w_op;

    assign in_ready  = (r_state != S_FIRE) && (r_state != S_WAIT);
    assign busy      = !in_ready;
    assign w_xfer    = in_valid && in_ready;
    assign w_op      = in_data[7:6];
    assign w_last    = r_cnt == CW'(NE - 1);
    assign w_both    = r_w_loaded && r_a_loaded;
    assign w_flat    = r_w;
    assign a_flat    = r_a;
    assign mat_start = r_mat_start;
    assign err       = r_err;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] r_tcnt;

    // WAIT-cycle watchdog: zero outside WAIT so it starts fresh on every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tcnt <= '0;
        else     r_tcnt <= (r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
    end

    // a done in the same cycle as expiry wins, so err stays clear
    assign w_timeout = (r_state == S_WAIT) && !mat_done && (r_tcnt == TW'(TIMEOUT - 1));
`else
    // without the watchdog WAIT only ends on mat_done; TIMEOUT is a non-negative limit so this is always 0
    assign w_timeout = (TIMEOUT < 0);
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state decode: headers only in IDLE, payload bytes never decoded
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer) w_next = (w_op == 2'b00) ? S_LOAD_W :
                                           (w_op == 2'b01) ? S_LOAD_A :
                                           (w_op == 2'b10 && w_both) ? S_FIRE : S_IDLE;
            S_LOAD_W,
            S_LOAD_A: if (w_xfer && w_last) w_next = S_IDLE;
            S_FIRE:   w_next = S_WAIT;
            S_WAIT:   if (mat_done || w_timeout) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // matrix storage, byte counter, loaded flags, sticky error and start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w         <= '0;
            r_a         <= '0;
            r_cnt       <= '0;
            r_w_loaded  <= 1'b0;
            r_a_loaded  <= 1'b0;
            r_err       <= 1'b0;
            r_mat_start <= 1'b0;
        end else begin
            r_mat_start <= (w_next == S_FIRE);
            if (w_timeout) r_err <= 1'b1;
            if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        if (w_op == 2'b10 && !w_both) r_err <= 1'b1;
                        if (w_op == 2'b11) begin
                            r_w_loaded <= 1'b0;
                            r_a_loaded <= 1'b0;
                            r_err      <= 1'b0;
                        end
                    end
                    S_LOAD_W: begin
                        r_w[r_cnt*DATA_W +: DATA_W] <= in_data;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) r_w_loaded <= 1'b1;
                    end
                    S_LOAD_A: begin
                        r_a[r_cnt*DATA_W +: DATA_W] <= in_data;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) r_a_loaded <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tpu_byte_loader.sv
// tb_tpu_byte_loader: directed self-checking bench for tpu_byte_loader
module tb_tpu_byte_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] w_flat, a_flat;
    logic        mat_start;
    logic        mat_done = 1'b0;
    logic        busy;
    logic        err;
    int          checks = 0;
    int          errors = 0;

    tpu_byte_loader #(.N(2), .DATA_W(8), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_flat(w_flat), .a_flat(a_flat), .mat_start(mat_start), .mat_done(mat_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (w_flat !== 32'h0 || a_flat !== 32'h0) begin errors++; $display("FAIL reset_mats got %h/%h want 0/0", w_flat, a_flat); end
        checks++; if (err !== 1'b0 || mat_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got err=%b start=%b busy=%b want 0", err, mat_start, busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_load();
        logic [7:0] seq [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40, 8'h05, 8'h06, 8'h07, 8'h08};
        int bad = 0;
        foreach (seq[i]) begin
            if (in_ready !== 1'b1) bad++;
            send(seq[i]);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL load_in_ready dropped %0d times want 0", bad); end
        checks++; if (w_flat !== 32'h04030201) begin errors++; $display("FAIL load_w got %h want 04030201", w_flat); end
        checks++; if (a_flat !== 32'h08070605) begin errors++; $display("FAIL load_a got %h want 08070605", a_flat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", err); end
    endtask

    task automatic test_fire();
        int starts = 0;
        int bad = 0;
        send(8'h80);
        checks++; if (mat_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fire_cycle got start=%b busy=%b rdy=%b want 1 1 0", mat_start, busy, in_ready); end
        starts += int'(mat_start);
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            starts += int'(mat_start);
            if (busy !== 1'b1 || in_ready !== 1'b0 || w_flat !== 32'h04030201 || a_flat !== 32'h08070605) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_hold bad cycles %0d want 0", bad); end
        mat_done = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_before_done busy got %b want 1", busy); end
        idle_cycle();
        mat_done = 1'b0;
        checks++; if (starts != 1) begin errors++; $display("FAIL start_pulses got %0d want 1", starts); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after_done got busy=%b rdy=%b want 0 1", busy, in_ready); end
    endtask

    task automatic test_back_to_back();
        send(8'h80);
        checks++; if (mat_start !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rerun got start=%b err=%b want 1 0", mat_start, err); end
        mat_done = 1'b1;
        idle_cycle();
        idle_cycle();
        mat_done = 1'b0;
        checks++; if (busy !== 1'b0 || mat_start !== 1'b0) begin errors++; $display("FAIL rerun_done got busy=%b start=%b want 0 0", busy, mat_start); end
        mat_done = 1'b1;
        idle_cycle();
        mat_done = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL done_in_idle got busy=%b rdy=%b want 0 1", busy, in_ready); end
    endtask

    task automatic test_err();
        int starts = 0;
        pulse_reset();
        send(8'h80);
        starts += int'(mat_start);
        idle_cycle();
        starts += int'(mat_start);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL start_unloaded err got %b want 1", err); end
        checks++; if (starts != 0 || in_ready !== 1'b1) begin errors++; $display("FAIL start_unloaded got starts=%0d rdy=%b want 0 1", starts, in_ready); end
        send(8'hC0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear err got %b want 0", err); end
    endtask

    task automatic test_stall_payload();
        int bad = 0;
        send(8'h00);
        idle_cycle();
        send(8'h11);
        idle_cycle();
        idle_cycle();
        send(8'h80);
        if (in_ready !== 1'b1 || busy !== 1'b0 || mat_start !== 1'b0) bad++;
        idle_cycle();
        send(8'h22);
        send(8'h33);
        checks++; if (bad != 0) begin errors++; $display("FAIL payload_80 treated as header"); end
        checks++; if (w_flat !== 32'h33228011) begin errors++; $display("FAIL stall_w got %h want 33228011", w_flat); end
        send(8'h80);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || w_flat !== 32'h33228011) begin errors++; $display("FAIL back_in_idle got err=%b busy=%b w=%h want 1 0 33228011", err, busy, w_flat); end
    endtask

    task automatic test_sticky_fire();
        send(8'h41); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        checks++; if (a_flat !== 32'hA4A3A2A1) begin errors++; $display("FAIL header_low_bits a got %h want a4a3a2a1", a_flat); end
        send(8'h9F);
        checks++; if (mat_start !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL sticky_fire got start=%b err=%b want 1 1", mat_start, err); end
        mat_done = 1'b1;
        idle_cycle();
        idle_cycle();
        mat_done = 1'b0;
        send(8'hC0);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sticky_clear got err=%b busy=%b want 0 0", err, busy); end
    endtask

    task automatic test_abort();
        send(8'h00);
        send(8'hAA);
        send(8'hBB);
        pulse_reset();
        checks++; if (w_flat !== 32'h0 || a_flat !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_load got w=%h a=%h rdy=%b want 0 0 1", w_flat, a_flat, in_ready); end
        send(8'h80);
        checks++; if (err !== 1'b1 || mat_start !== 1'b0) begin errors++; $display("FAIL abort_start got err=%b start=%b want 1 0", err, mat_start); end
        send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h40); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        send(8'h80);
        idle_cycle();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || w_flat !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL abort_wait got busy=%b rdy=%b w=%h err=%b want 0 1 0 0", busy, in_ready, w_flat, err); end
        #1;
        rst = 1'b0;
        idle_cycle();
        checks++; if (mat_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_start got start=%b busy=%b want 0 0", mat_start, busy); end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        pulse_reset();
        send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h40); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        send(8'h80);
        while (busy === 1'b1 && n < 100) begin
            n++;
            idle_cycle();
        end
        checks++; if (n != 21) begin errors++; $display("FAIL timeout_cycles got %0d want 21", n); end
        checks++; if (err !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL timeout_state got err=%b rdy=%b want 1 1", err, in_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_fire();
        test_back_to_back();
        test_err();
        test_stall_payload();
        test_sticky_fire();
        test_abort();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpu_byte_loader.md
Name: tpu_byte_loader

Overview:
- Byte-serial command front end of the TinyTPU core; consumes the 8-bit input pad stream and drives the matrix-multiply datapath downstream.
- Decodes header bytes and assembles an NxN weight matrix and an NxN activation matrix in local registers.
- Issues a one-cycle start pulse to the systolic array, then holds off new input until the array reports done.

Parameters:
- N, 2, matrix dimension; payload per load is N*N bytes.
- DATA_W, 8, element width in bits; fixed equal to the byte width.
- TIMEOUT, 255, watchdog limit in cycles; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  header or payload byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- w_flat  out  N*N*DATA_W  weight matrix, row-major; element k is at bits [k*8+7:k*8].
- a_flat  out  N*N*DATA_W  activation matrix, same packing as w_flat.
- mat_start  out  1  one-cycle pulse that starts the array.
- mat_done  in  1  array completion pulse or level; sampled only in WAIT.
- busy  out  1  high in FIRE and WAIT.
- err  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; w_flat=0, a_flat=0; byte counter=0.
  - w_loaded=0, a_loaded=0, err=0, mat_start=0.
  - in_ready reads 1 (IDLE) as soon as rst deasserts.
- in_ready = 1 in IDLE, LOAD_W and LOAD_A; 0 in FIRE and WAIT. It is decoded from state only, never from in_valid.
- Header decode in IDLE uses opcode = in_data[7:6]; in_data[5:0] is ignored.
  - 00 -> LOAD_W, counter=0.
  - 01 -> LOAD_A, counter=0.
  - 10 (START): if w_loaded & a_loaded -> FIRE; otherwise set err and stay in IDLE.
  - 11 (CLEAR): w_loaded=0, a_loaded=0, err=0; matrix registers keep their contents.
- LOAD_W / LOAD_A:
  - Each accepted byte writes element[counter] of the target matrix; counter increments.
  - On the byte with counter==N*N-1: set the matching loaded flag, counter wraps to 0, return to IDLE.
  - Cycles with in_valid=0 stall with no change.
  - Bytes are never interpreted as headers while in a load state.
- Reloading a matrix already marked loaded overwrites it in place. The flag stays 1 throughout; partial-overwrite visibility is acceptable.
- FIRE:
  - mat_start=1 for exactly this one cycle (registered output, asserted the cycle after the START header is accepted).
  - Unconditional transition to WAIT.
- WAIT:
  - Stay until mat_done=1, then IDLE on the next edge.
  - w_flat and a_flat are held stable throughout FIRE and WAIT.
  - mat_done outside WAIT is ignored.
- After a completed run, loaded flags stay set, so a repeated START reruns with the same operands.
- err is sticky. It is cleared only by CLEAR or rst; a START with err=1 and both flags set still fires.
- rst asserted mid-load or mid-WAIT aborts immediately to the reset state. Partial matrices are zeroed and no mat_start is produced.
- Counter width is clog2(N*N); the counter never exceeds N*N-1.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum cycle counter starts at 0 on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mat_done: go to IDLE, set err.
  - mat_done and timeout in the same cycle -> treated as done; err is not set.
- Undefined: no counter is synthesised; WAIT waits indefinitely for mat_done.

Test Plan:
- Reset, then stream 0x00,01,02,03,04 and 0x40,05,06,07,08 -> w_flat=0x04030201, a_flat=0x08070605; in_ready stays 1 throughout; err=0.
- After the load above, send 0x80; hold mat_done=0 for 10 cycles, then pulse it -> mat_start high exactly 1 cycle; busy=1 and in_ready=0 until the cycle after mat_done; then IDLE.
- Reset, then send 0x80 with no loads -> err=1, mat_start never pulses, in_ready stays 1; then send 0xC0 -> err=0.
- During LOAD_W, interleave in_valid=0 gaps and send byte 0x80 as payload -> 0x80 is stored as an element, not treated as START; state returns to IDLE after the 4th byte.
- Assert rst for 1 cycle after the 2nd weight byte -> w_flat=0, w_loaded=0; a following 0x80 sets err.
- With LOADER_TIMEOUT_EN and TIMEOUT=20, send START and never assert mat_done -> return to IDLE after 20 WAIT cycles, err=1, in_ready=1.
